// File: rtl/finalsoc_spi_slave.sv
// CPOL=0/CPHA=0 8-bit MSB-first SPI slave behind the SoC SPI register map.
// Build with SPI_SLAVE_EOP_EN defined to add end-of-packet detection (addr 6, status/control bit 9).
module finalsoc_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO
);
    localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_STAT = 3'd2, A_CTRL = 3'd3, A_EOP = 3'd6;
`ifdef SPI_SLAVE_EOP_EN
    localparam logic [15:0] CTRL_MASK = 16'h03DC;
`else
    localparam logic [15:0] CTRL_MASK = 16'h01DC;
`endif

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic sclk_hist_q, ss_hist_q, armed_q;
    logic sclk_s, mosi_s, ss_s, active;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic rd_stb, wr_stb, wr_tx, wr_stat, wr_ctrl;
    logic rx_rise, byte_cmp, tx_load;
    logic [7:0]  rx_next;
    logic [15:0] status;
    logic        eop_flag;
    logic [15:0] eop_val;

    logic rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, unr_q, unr_d;
    logic tx_primed_q, tx_primed_d, byte_done_q, byte_done_d;
    logic [7:0] tx_holding_q, tx_holding_d, tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d, rx_holding_q, rx_holding_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [15:0] ctrl_q, ctrl_d, data_q, data_d;
    logic rd_fired_q, rd_fired_d, wr_fired_q, wr_fired_d, rd_clr_q, rd_clr_d;
    logic miso_q, miso_d, irq_q, irq_d;

    // armed_q blocks a transfer until SS_n has been seen idle after reset,
    // so a reset in the middle of a selected transfer stays quiet until the next falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
            sclk_hist_q <= sclk_s;
            ss_hist_q   <= ss_s;
            armed_q     <= armed_q | ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign active    = ~ss_s & armed_q;
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign ss_fall   = ~ss_s & ss_hist_q;
    assign ss_rise   = ss_s & ~ss_hist_q;

    assign rd_stb  = spi_select & ~read_n & ~rd_fired_q;
    assign wr_stb  = spi_select & ~write_n & ~wr_fired_q;
    assign wr_tx   = wr_stb & (mem_addr == A_TX);
    assign wr_stat = wr_stb & (mem_addr == A_STAT);
    assign wr_ctrl = wr_stb & (mem_addr == A_CTRL);

    assign rx_rise  = sclk_rise & active;
    assign rx_next  = {rx_shift_q[6:0], mosi_s};
    assign byte_cmp = rx_rise & (bitcnt_q == 3'd7);
    assign tx_load  = ss_fall | (sclk_fall & active & byte_done_q);

    assign status = {6'b0, eop_flag, toe_q | roe_q, rrdy_q, ~tx_primed_q,
                     ~tx_primed_q & ~active, toe_q, roe_q, unr_q, 2'b00};

    always_comb begin
        rrdy_d       = rrdy_q;
        roe_d        = roe_q;
        toe_d        = toe_q;
        unr_d        = unr_q;
        tx_primed_d  = tx_primed_q;
        byte_done_d  = byte_done_q;
        tx_holding_d = tx_holding_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        rx_holding_d = rx_holding_q;
        bitcnt_d     = bitcnt_q;
        ctrl_d       = ctrl_q;
        rd_fired_d   = rd_stb;
        wr_fired_d   = wr_stb;
        rd_clr_d     = rd_stb & (mem_addr == A_RX);

        // Clears come first so a flag set in the same cycle wins.
        if (wr_stat) begin
            rrdy_d = 1'b0;
            roe_d  = 1'b0;
            toe_d  = 1'b0;
            unr_d  = 1'b0;
        end
        if (rd_clr_q) rrdy_d = 1'b0;
        if (wr_ctrl) ctrl_d = data_from_cpu & CTRL_MASK;

        if (ss_fall || ss_rise) begin
            bitcnt_d    = '0;
            byte_done_d = 1'b0;
        end

        if (tx_load) begin
            tx_shift_d  = tx_primed_q ? tx_holding_q : 8'h00;
            unr_d       = unr_d | ~tx_primed_q;
            tx_primed_d = 1'b0;
            byte_done_d = 1'b0;
        end else if (sclk_fall && active) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        if (rx_rise) begin
            rx_shift_d = rx_next;
            bitcnt_d   = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                rx_holding_d = rx_next;
                rrdy_d       = 1'b1;
                byte_done_d  = 1'b1;
                if (rrdy_q && !rd_clr_q) roe_d = 1'b1;
            end
        end

        // A CPU load beside a shift-register load keeps the new byte primed.
        if (wr_tx) begin
            if (tx_primed_q) begin
                toe_d = 1'b1;
            end else begin
                tx_holding_d = data_from_cpu[7:0];
                tx_primed_d  = 1'b1;
            end
        end

        miso_d = active & tx_shift_q[7];
        irq_d  = |(status & ctrl_q);

        case (mem_addr)
            A_RX:    data_d = {8'h00, rx_holding_q};
            A_STAT:  data_d = status;
            A_CTRL:  data_d = ctrl_q;
            A_EOP:   data_d = eop_val;
            default: data_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrdy_q       <= 1'b0;
            roe_q        <= 1'b0;
            toe_q        <= 1'b0;
            unr_q        <= 1'b0;
            tx_primed_q  <= 1'b0;
            byte_done_q  <= 1'b0;
            tx_holding_q <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            rx_holding_q <= '0;
            bitcnt_q     <= '0;
            ctrl_q       <= '0;
            data_q       <= '0;
            rd_fired_q   <= 1'b0;
            wr_fired_q   <= 1'b0;
            rd_clr_q     <= 1'b0;
            miso_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            rrdy_q       <= rrdy_d;
            roe_q        <= roe_d;
            toe_q        <= toe_d;
            unr_q        <= unr_d;
            tx_primed_q  <= tx_primed_d;
            byte_done_q  <= byte_done_d;
            tx_holding_q <= tx_holding_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            rx_holding_q <= rx_holding_d;
            bitcnt_q     <= bitcnt_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            rd_fired_q   <= rd_fired_d;
            wr_fired_q   <= wr_fired_d;
            rd_clr_q     <= rd_clr_d;
            miso_q       <= miso_d;
            irq_q        <= irq_d;
        end
    end

`ifdef SPI_SLAVE_EOP_EN
    logic        eop_q, eop_d;
    logic [15:0] eopv_q, eopv_d;

    always_comb begin
        eop_d  = eop_q;
        eopv_d = eopv_q;
        if (wr_stb && mem_addr == A_EOP) eopv_d = data_from_cpu;
        if (wr_stat) eop_d = 1'b0;
        if ((byte_cmp && rx_next == eopv_q[7:0]) ||
            (wr_tx && data_from_cpu[7:0] == eopv_q[7:0])) eop_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eop_q  <= 1'b0;
            eopv_q <= '0;
        end else begin
            eop_q  <= eop_d;
            eopv_q <= eopv_d;
        end
    end

    assign eop_flag = eop_q;
    assign eop_val  = eopv_q;
`else
    assign eop_flag = 1'b0;
    assign eop_val  = 16'h0000;
`endif

    assign data_to_cpu   = data_q;
    assign irq           = irq_q;
    assign MISO          = miso_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = ~tx_primed_q;
    assign endofpacket   = eop_flag;
endmodule

// File: tb/tb_finalsoc_spi_slave.sv
// Directed/randomized bench for finalsoc_spi_slave; the model tracks flags and bytes per transfer.
module tb_finalsoc_spi_slave;
    localparam int SYNC_STAGES = 2;
    localparam int HALF = 10;
`ifdef SPI_SLAVE_EOP_EN
    localparam bit EOP_EN = 1'b1;
`else
    localparam bit EOP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, spi_select, read_n, write_n, SCLK, MOSI, SS_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic irq, dataavailable, readyfordata, endofpacket, MISO;

    finalsoc_spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata), .endofpacket(endofpacket),
        .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_rrdy, m_roe, m_toe, m_unr, m_eop, m_primed;
    logic [7:0]  m_hold, m_rx;
    logic [15:0] m_ctrl, m_eopv;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        m_rrdy = 0; m_roe = 0; m_toe = 0; m_unr = 0; m_eop = 0; m_primed = 0;
        m_hold = 0; m_rx = 0; m_ctrl = 0; m_eopv = 0;
    endtask

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s = 16'h0;
        if (EOP_EN && m_eop)  s += 16'd512;
        if (m_toe || m_roe)   s += 16'd256;
        if (m_rrdy)           s += 16'd128;
        if (!m_primed)        s += 16'd64 + 16'd32;
        if (m_toe)            s += 16'd16;
        if (m_roe)            s += 16'd8;
        if (m_unr)            s += 16'd4;
        return s;
    endfunction

    function automatic logic exp_irq();
        return |(exp_status() & m_ctrl);
    endfunction

    // Byte that goes into the shifter at a select edge or byte boundary.
    task automatic mdl_load(output logic [7:0] b);
        b = m_primed ? m_hold : 8'h00;
        if (!m_primed) m_unr = 1;
        m_primed = 0;
    endtask

    task automatic mdl_rx(input logic [7:0] b);
        if (m_rrdy) m_roe = 1;
        m_rrdy = 1;
        m_rx = b;
        if (EOP_EN && b == m_eopv[7:0]) m_eop = 1;
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        spi_select = 1; mem_addr = a; data_from_cpu = d; write_n = 0;
        tick(2);
        write_n = 1; spi_select = 0;
        tick(1);
        case (a)
            3'd1: begin
                if (EOP_EN && d[7:0] == m_eopv[7:0]) m_eop = 1;
                if (m_primed) m_toe = 1;
                else begin m_hold = d[7:0]; m_primed = 1; end
            end
            3'd2: begin m_rrdy = 0; m_roe = 0; m_toe = 0; m_unr = 0; m_eop = 0; end
            3'd3: m_ctrl = d & (EOP_EN ? 16'h03DC : 16'h01DC);
            3'd6: if (EOP_EN) m_eopv = d;
            default: ;
        endcase
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        spi_select = 1; mem_addr = a; read_n = 0;
        tick(1);
        d = data_to_cpu;
        tick(1);
        read_n = 1; spi_select = 0;
        tick(1);
        if (a == 3'd0) m_rrdy = 0;
    endtask

    // Master side: n bits MSB first; returns received bits right-aligned.
    task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi, input bit chk_lat);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = mo[7-i];
            tick(HALF);
            mi = {mi[6:0], MISO};
            SCLK = 1;
            if (chk_lat && i == n - 1) begin
                tick(SYNC_STAGES);
                check("rrdy_lat_before", {15'b0, dataavailable}, 16'd0);
                tick(1);
                check("rrdy_lat_at", {15'b0, dataavailable}, 16'd1);
                tick(HALF - SYNC_STAGES - 1);
            end else begin
                tick(HALF);
            end
            SCLK = 0;
        end
    endtask

    task automatic ss_end();
        tick(HALF);
        SS_n = 1;
        tick(HALF);
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] rd;
        cpu_read(3'd2, rd);
        check({tag, "_status"}, rd, exp_status());
        check({tag, "_irq"}, {15'b0, irq}, {15'b0, exp_irq()});
        check({tag, "_trdy"}, {15'b0, readyfordata}, {15'b0, !m_primed});
    endtask

    // One complete single-byte transfer with the model following along.
    task automatic xfer(input string tag, input logic [7:0] mo);
        logic [7:0] exp_b, got, dummy;
        SS_n = 0;
        mdl_load(exp_b);
        spi_bits(8, mo, got, 1'b0);
        mdl_rx(mo);
        mdl_load(dummy);
        ss_end();
        check({tag, "_miso"}, {8'h0, got}, {8'h0, exp_b});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [7:0]  got, t, r, r2, e1, e2, dummy;

        reset = 1; spi_select = 0; read_n = 1; write_n = 1; mem_addr = 3'd0;
        data_from_cpu = 16'h0; SCLK = 0; MOSI = 0; SS_n = 1;
        mdl_reset();
        tick(2);
        check("rst_data", data_to_cpu, 16'h0000);
        check("rst_miso", {15'b0, MISO}, 16'd0);
        check("rst_irq", {15'b0, irq}, 16'd0);
        check("rst_rfd", {15'b0, readyfordata}, 16'd1);
        check("rst_da", {15'b0, dataavailable}, 16'd0);
        check("rst_eop", {15'b0, endofpacket}, 16'd0);
        reset = 0;
        tick(4);
        cpu_read(3'd2, rd);
        check("rst_status", rd, 16'h0060);

        // Single byte with pin-to-MISO and SCLK-to-RRDY latency
        cpu_write(3'd1, 16'h00A5);
        check("single_trdy0", {15'b0, readyfordata}, 16'd0);
        SS_n = 0;
        mdl_load(e1);
        tick(SYNC_STAGES + 1);
        check("miso_lat_before", {15'b0, MISO}, 16'd0);
        tick(1);
        check("miso_lat_at", {15'b0, MISO}, 16'd1);
        spi_bits(8, 8'h3C, got, 1'b1);
        mdl_rx(8'h3C);
        mdl_load(dummy);
        ss_end();
        check("single_miso", {8'h0, got}, 16'h00A5);
        check_regs("single");
        cpu_read(3'd0, rd);
        check("single_rx", rd, 16'h003C);
        check("single_rrdy_clr", {15'b0, dataavailable}, 16'd0);
        check_regs("single_after_read");
        cpu_write(3'd2, 16'hFFFF);

        // Control register readback and masking
        cpu_write(3'd3, 16'hFFFF);
        cpu_read(3'd3, rd);
        check("ctrl_rb", rd, m_ctrl);
        cpu_write(3'd3, 16'h0000);

        // Randomized single-byte transfers with random interrupt enables
        for (int k = 0; k < 6; k++) begin
            t = 8'($urandom);
            r = 8'($urandom);
            cpu_write(3'd3, 16'($urandom));
            if ((k % 3) != 2) cpu_write(3'd1, {8'h00, t});
            xfer("rand", r);
            check_regs("rand");
            cpu_read(3'd0, rd);
            check("rand_rx", rd, {8'h0, m_rx});
            check_regs("rand_read");
            cpu_write(3'd2, 16'h0000);
            check_regs("rand_clr");
        end
        cpu_write(3'd3, 16'h0000);

        // Two-byte burst: second byte written after the first load, ROE with iROE
        cpu_write(3'd3, 16'h0008);
        r = 8'($urandom);
        r2 = 8'($urandom);
        cpu_write(3'd1, 16'h0011);
        SS_n = 0;
        mdl_load(e1);
        tick(SYNC_STAGES + 3);
        cpu_write(3'd1, 16'h0022);
        spi_bits(8, r, got, 1'b0);
        mdl_rx(r);
        mdl_load(e2);
        check("burst_b0", {8'h0, got}, {8'h0, e1});
        spi_bits(8, r2, got, 1'b0);
        mdl_rx(r2);
        mdl_load(dummy);
        ss_end();
        check("burst_b1", {8'h0, got}, {8'h0, e2});
        check("burst_irq", {15'b0, irq}, 16'd1);
        check_regs("burst");
        cpu_read(3'd0, rd);
        check("burst_rx", rd, {8'h0, r2});
        cpu_write(3'd2, 16'h0000);
        check_regs("burst_clr");
        cpu_write(3'd3, 16'h0000);

        // Underrun: no txdata written
        xfer("unr", 8'($urandom));
        check_regs("unr");
        cpu_read(3'd0, rd);
        cpu_write(3'd2, 16'h0000);
        check_regs("unr_clr");

        // TX overrun, then a transfer aborted after 5 bits
        cpu_write(3'd1, 16'h005A);
        cpu_write(3'd1, 16'h0077);
        check_regs("toe");
        SS_n = 0;
        mdl_load(e1);
        spi_bits(5, 8'($urandom), got, 1'b0);
        ss_end();
        check("abort_miso", {8'h0, got}, {8'h0, 3'b000, e1[7:3]});
        check("abort_rrdy", {15'b0, dataavailable}, 16'd0);
        check_regs("abort");
        cpu_write(3'd2, 16'h0000);
        t = 8'($urandom);
        cpu_write(3'd1, {8'h00, t});
        xfer("post_abort", 8'hC3);
        cpu_read(3'd0, rd);
        check("post_abort_rx", rd, 16'h00C3);
        cpu_write(3'd2, 16'h0000);

        // Reset with SS_n held low: no transfer until the next falling edge
        cpu_write(3'd1, 16'h00FF);
        SS_n = 0;
        spi_bits(3, 8'hFF, got, 1'b0);
        reset = 1;
        tick(2);
        reset = 0;
        mdl_reset();
        spi_bits(8, 8'hFF, got, 1'b0);
        check("rst_mid_miso", {8'h0, got}, 16'h0000);
        check("rst_mid_rrdy", {15'b0, dataavailable}, 16'd0);
        ss_end();
        check_regs("rst_mid");
        xfer("rst_mid_next", 8'h96);
        cpu_read(3'd0, rd);
        check("rst_mid_rx", rd, 16'h0096);
        cpu_write(3'd2, 16'h0000);

        // End-of-packet detection
        cpu_write(3'd6, 16'h000D);
        cpu_read(3'd6, rd);
        check("eop_rb", rd, EOP_EN ? 16'h000D : 16'h0000);
        xfer("eop", 8'h0D);
        check("eop_pin", {15'b0, endofpacket}, {15'b0, EOP_EN});
        check_regs("eop");
        cpu_write(3'd2, 16'h0000);
        check("eop_clr", {15'b0, endofpacket}, 16'd0);
        cpu_write(3'd3, 16'h0200);
        cpu_write(3'd1, 16'h000D);
        check("eop_wr_pin", {15'b0, endofpacket}, {15'b0, EOP_EN});
        check_regs("eop_wr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
